// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory path: data word, load/store width codes
// and the memory arbiter state encoding.
package rv32ima_pkg;

  localparam int LDST_WIDTH_W = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [LDST_WIDTH_W-1:0] {
    LDST_BYTE = 2'd0,
    LDST_HALF = 2'd1,
    LDST_WORD = 2'd2
  } ldst_width_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    DONE
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_ldst_align.sv
// Byte-lane steering: store replication and byte enables, plus load extraction
// with zero extension. Width code 3 falls through to word behaviour.
module ldst_align
  import rv32ima_pkg::*;
(
  input  logic [LDST_WIDTH_W-1:0] width_i,
  input  logic [1:0]              addr_lo_i,
  input  word_t                   store_i,
  input  word_t                   rdata_i,
  output word_t                   wdata_o,
  output logic [3:0]              be_o,
  output word_t                   load_o
);

  always_comb begin
    wdata_o = store_i;
    be_o    = 4'hF;
    load_o  = rdata_i;
    case (width_i)
      LDST_BYTE: begin
        wdata_o = {4{store_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
        load_o  = {24'b0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
      end
      LDST_HALF: begin
        wdata_o = {2{store_i[15:0]}};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        load_o  = {16'b0, (addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and loads/stores onto one single-ported RAM.
// Define MEM_ARBITER_MISALIGN_CHECK_EN to add dmem_fault and reject misaligned half/word accesses.
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int RAM_AW     = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    imem_ren,
  input  logic [31:0]             imem_addr,
  output logic [31:0]             imem_load,
  output logic                    ihit,
  input  logic                    dmem_ren,
  input  logic                    dmem_wen,
  input  logic [31:0]             dmem_addr,
  input  logic [31:0]             dmem_store,
  input  logic [LDST_WIDTH_W-1:0] dmem_width,
  output logic [31:0]             dmem_load,
  output logic                    dhit,
  output logic                    ram_req,
  output logic                    ram_wen,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [31:0]             ram_wdata,
  output logic [3:0]              ram_be,
  input  logic [31:0]             ram_rdata,
  input  logic                    ram_ready
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  ,
  output logic                    dmem_fault
`endif
);

  mem_arb_state_t          state_q;
  logic                    ram_req_q, ram_wen_q, ihit_q, dhit_q;
  logic [RAM_AW-1:0]       ram_addr_q;
  word_t                   ram_wdata_q, imem_load_q, dmem_load_q;
  logic [3:0]              ram_be_q;
  logic [LDST_WIDTH_W-1:0] width_q;
  logic [1:0]              addr_lo_q;

  logic                    d_req, take_data;
  logic [LDST_WIDTH_W-1:0] align_width;
  logic [1:0]              align_lo;
  word_t                   st_wdata, ld_data;
  logic [3:0]              st_be;
  logic                    unused_addr_bits;

  assign d_req     = dmem_ren | dmem_wen;
  assign take_data = d_req && (DATA_FIRST || !imem_ren);
  assign unused_addr_bits = ^{imem_addr[31:RAM_AW+2], imem_addr[1:0], dmem_addr[31:RAM_AW+2]};

  // Live request drives store steering in IDLE; the latched request drives load extraction later.
  assign align_width = (state_q == IDLE) ? dmem_width : width_q;
  assign align_lo    = (state_q == IDLE) ? dmem_addr[1:0] : addr_lo_q;

  ldst_align u_align (
    .width_i   (align_width),
    .addr_lo_i (align_lo),
    .store_i   (dmem_store),
    .rdata_i   (ram_rdata),
    .wdata_o   (st_wdata),
    .be_o      (st_be),
    .load_o    (ld_data)
  );

`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  logic fault_q;
  logic misaligned;
  assign misaligned = (dmem_width == LDST_HALF) ? dmem_addr[0]
                    : ((dmem_width != LDST_BYTE) && (dmem_addr[1:0] != 2'b00));
  assign dmem_fault = fault_q;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      imem_load_q <= '0;
      dmem_load_q <= '0;
      width_q     <= '0;
      addr_lo_q   <= '0;
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (take_data) begin
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
            if (misaligned) begin
              state_q     <= DONE;
              dhit_q      <= 1'b1;
              fault_q     <= 1'b1;
              dmem_load_q <= '0;
            end else
`endif
            begin
              state_q     <= DACC;
              ram_req_q   <= 1'b1;
              ram_wen_q   <= dmem_wen;
              ram_addr_q  <= dmem_addr[RAM_AW+1:2];
              ram_wdata_q <= dmem_wen ? st_wdata : '0;
              ram_be_q    <= dmem_wen ? st_be : 4'hF;
              width_q     <= dmem_width;
              addr_lo_q   <= dmem_addr[1:0];
            end
          end else if (imem_ren) begin
            state_q     <= IACC;
            ram_req_q   <= 1'b1;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= imem_addr[RAM_AW+1:2];
            ram_wdata_q <= '0;
            ram_be_q    <= 4'hF;
          end
        end
        IACC: begin
          if (ram_ready) begin
            ram_req_q <= 1'b0;
            state_q   <= DONE;
            if (imem_ren) begin
              ihit_q      <= 1'b1;
              imem_load_q <= ram_rdata;
            end
          end
        end
        DACC: begin
          // A withdrawn request still lets the RAM finish, but the result is dropped.
          if (ram_ready) begin
            ram_req_q <= 1'b0;
            state_q   <= DONE;
            if (d_req) begin
              dhit_q <= 1'b1;
              if (!ram_wen_q) dmem_load_q <= ld_data;
            end
          end
        end
        DONE: begin
          ihit_q  <= 1'b0;
          dhit_q  <= 1'b0;
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
          fault_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign imem_load = imem_load_q;
  assign dmem_load = dmem_load_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM model and an expected-hit scoreboard.
module tb_mem_arbiter;
  import rv32ima_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_load;
  logic        ihit;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_store;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_load;
  logic        dhit;
  logic        ram_req, ram_wen;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        ram_ready;
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  logic        dmem_fault;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_AW(16), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width), .dmem_load(dmem_load), .dhit(dhit),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
    , .dmem_fault(dmem_fault)
`endif
  );

  // Behavioural RAM: ready after stall_cycles cycles of ram_req, byte-enabled writes.
  logic [31:0] mem [0:255];
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a;
  logic [31:0] poke_d;

  assign ram_ready = ram_req && (stall_cnt >= stall_cycles);
  assign ram_rdata = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (ram_req && ram_ready && ram_wen)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_req && !ram_ready) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    checks++;
    if ({ihit, dhit, ram_req, ram_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ihit,dhit,req,wen=%b required 0000", {ihit, dhit, ram_req, ram_wen});
    end
    checks++;
    if (ram_addr !== 16'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram: addr=%h be=%h wdata=%h required all 0", ram_addr, ram_be, ram_wdata);
    end
    checks++;
    if (imem_load !== 32'h0 || dmem_load !== 32'h0) begin
      errors++;
      $display("FAIL reset_load: imem_load=%h dmem_load=%h required 0", imem_load, dmem_load);
    end
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
    checks++;
    if (dmem_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: dmem_fault=%b required 0", dmem_fault);
    end
`endif
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    exp_t e;
    poke(8'h40, 32'h00A00093);
    stall_cycles = 0;
    imem_ren  = 1'b1;
    imem_addr = 32'h100;
    sb.push_back('{1'b0, 1'b1, 32'h00A00093});
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_addr !== 16'h40 || ram_wen !== 1'b0 || ram_be !== 4'hF) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h wen=%b be=%h required 1 0040 0 f", ram_req, ram_addr, ram_wen, ram_be);
    end
    tick();
    checks++;
    if (ihit !== 1'b1 || dhit !== 1'b0) begin
      errors++;
      $display("FAIL fetch_latency: ihit=%b dhit=%b at cycle 2 required ihit=1 dhit=0", ihit, dhit);
    end
    if (ihit === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (imem_load !== e.data) begin
        errors++;
        $display("FAIL fetch_data: imem_load=%h required %h", imem_load, e.data);
      end
    end
    imem_ren = 1'b0;
    tick();
    checks++;
    if (ihit !== 1'b0 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_bubble: ihit=%b req=%b required 0 0", ihit, ram_req);
    end
    sb.delete();
  endtask

  task automatic test_contention();
    exp_t e;
    int   hits;
    bit   saw_d, gap_low;
    poke(8'h00, 32'h11111111);
    poke(8'h80, 32'hCAFEBABE);
    imem_ren   = 1'b1;
    imem_addr  = 32'h0;
    dmem_ren   = 1'b1;
    dmem_addr  = 32'h200;
    dmem_width = 2'd2;
    sb.push_back('{1'b1, 1'b1, 32'hCAFEBABE});
    sb.push_back('{1'b0, 1'b1, 32'h11111111});
    hits = 0;
    saw_d = 1'b0;
    gap_low = 1'b0;
    for (int c = 0; c < 40 && hits < 2; c++) begin
      tick();
      if (ihit === 1'b1 || dhit === 1'b1) begin
        hits++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (dhit !== e.is_data || ihit === e.is_data) begin
            errors++;
            $display("FAIL contention_order: ihit=%b dhit=%b required data_hit=%b", ihit, dhit, e.is_data);
          end
          checks++;
          if ((e.is_data ? dmem_load : imem_load) !== e.data) begin
            errors++;
            $display("FAIL contention_data: load=%h required %h", e.is_data ? dmem_load : imem_load, e.data);
          end
        end
        if (dhit === 1'b1) begin
          dmem_ren = 1'b0;
          saw_d = 1'b1;
        end
        if (ihit === 1'b1) imem_ren = 1'b0;
      end
      if (saw_d && ihit !== 1'b1 && ram_req === 1'b0) gap_low = 1'b1;
    end
    checks++;
    if (hits != 2) begin
      errors++;
      $display("FAIL contention_timeout: hits=%0d required 2", hits);
    end
    checks++;
    if (!gap_low) begin
      errors++;
      $display("FAIL contention_gap: ram_req low between hits=%b required 1", gap_low);
    end
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    sb.delete();
    tick();
  endtask

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [1:0]  w;
    logic [31:0] st;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } ls_t;

  task automatic test_store_load();
    ls_t  tbl[$];
    exp_t e;
    bit   got;
    tbl.push_back('{1'b1, 32'h203, 2'd0, 32'h12345678, 4'b1000, 32'h78787878, 32'h0});
    tbl.push_back('{1'b0, 32'h202, 2'd1, 32'h0, 4'hF, 32'h0, 32'h00007800});
    tbl.push_back('{1'b0, 32'h203, 2'd0, 32'h0, 4'hF, 32'h0, 32'h00000078});
    tbl.push_back('{1'b0, 32'h201, 2'd0, 32'h0, 4'hF, 32'h0, 32'h00000000});
    tbl.push_back('{1'b1, 32'h202, 2'd1, 32'hABCD1234, 4'b1100, 32'h12341234, 32'h0});
    tbl.push_back('{1'b0, 32'h200, 2'd3, 32'h0, 4'hF, 32'h0, 32'h12340000});
    tbl.push_back('{1'b1, 32'h200, 2'd2, 32'hA5A55A5A, 4'hF, 32'hA5A55A5A, 32'h0});
    tbl.push_back('{1'b0, 32'h200, 2'd1, 32'h0, 4'hF, 32'h0, 32'h00005A5A});
    tbl.push_back('{1'b1, 32'h200, 2'd0, 32'h000000EE, 4'b0001, 32'hEEEEEEEE, 32'h0});
    tbl.push_back('{1'b0, 32'h200, 2'd2, 32'h0, 4'hF, 32'h0, 32'hA5A55AEE});
    tbl.push_back('{1'b0, 32'h202, 2'd0, 32'h0, 4'hF, 32'h0, 32'h000000A5});
    poke(8'h80, 32'h0);
    stall_cycles = 0;
    foreach (tbl[i]) begin
      dmem_wen   = tbl[i].wen;
      dmem_ren   = ~tbl[i].wen;
      dmem_addr  = tbl[i].addr;
      dmem_width = tbl[i].w;
      dmem_store = tbl[i].st;
      sb.push_back('{1'b1, ~tbl[i].wen, tbl[i].ld});
      tick();
      checks++;
      if (ram_req !== 1'b1 || ram_wen !== tbl[i].wen || ram_addr !== 16'h80 || ram_be !== tbl[i].be ||
          (tbl[i].wen && ram_wdata !== tbl[i].wd)) begin
        errors++;
        $display("FAIL ldst_req[%0d]: req=%b wen=%b addr=%h be=%h wdata=%h required 1 %b 0080 %h %h",
                 i, ram_req, ram_wen, ram_addr, ram_be, ram_wdata, tbl[i].wen, tbl[i].be, tbl[i].wd);
      end
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        got = (dhit === 1'b1) || (ihit === 1'b1);
      end
      checks++;
      if (!got || dhit !== 1'b1) begin
        errors++;
        $display("FAIL ldst_hit[%0d]: got=%b dhit=%b required dhit=1", i, got, dhit);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (dmem_load !== e.data) begin
            errors++;
            $display("FAIL ldst_data[%0d]: dmem_load=%h required %h", i, dmem_load, e.data);
          end
        end
      end
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
      tick();
      if (i == 0) begin
        checks++;
        if (mem[8'h80] !== 32'h78000000) begin
          errors++;
          $display("FAIL byte_store_mem: word=%h required 78000000", mem[8'h80]);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_stall();
    exp_t        e;
    logic [15:0] a0;
    logic [3:0]  b0;
    int          hits;
    poke(8'h81, 32'hDEADBEEF);
    stall_cycles = 5;
    dmem_ren   = 1'b1;
    dmem_addr  = 32'h204;
    dmem_width = 2'd2;
    sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
    tick();
    a0 = ram_addr;
    b0 = ram_be;
    checks++;
    if (ram_req !== 1'b1 || a0 !== 16'h81 || b0 !== 4'hF) begin
      errors++;
      $display("FAIL stall_req: req=%b addr=%h be=%h required 1 0081 f", ram_req, a0, b0);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      checks++;
      if (ram_req !== 1'b1 || ram_addr !== a0 || ram_be !== b0 || dhit !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: req=%b addr=%h be=%h dhit=%b required 1 %h %h 0",
                 c, ram_req, ram_addr, ram_be, dhit, a0, b0);
      end
    end
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dhit === 1'b1) begin
        hits++;
        dmem_ren = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (dmem_load !== e.data) begin
            errors++;
            $display("FAIL stall_data: dmem_load=%h required %h", dmem_load, e.data);
          end
        end
      end
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL stall_hits: dhit pulses=%0d required 1", hits);
    end
    dmem_ren = 1'b0;
    stall_cycles = 0;
    sb.delete();
  endtask

`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
  task automatic test_misalign();
    bit req_seen, got;
    dmem_ren   = 1'b1;
    dmem_addr  = 32'h202;
    dmem_width = 2'd2;
    req_seen = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (ram_req === 1'b1) req_seen = 1'b1;
      got = (dhit === 1'b1);
    end
    checks++;
    if (!got || dmem_fault !== 1'b1 || dmem_load !== 32'h0 || req_seen) begin
      errors++;
      $display("FAIL misalign: dhit=%b fault=%b load=%h req_seen=%b required 1 1 0 0",
               got, dmem_fault, dmem_load, req_seen);
    end
    dmem_ren = 1'b0;
    tick();
    tick();
  endtask
`endif

  task automatic test_withdraw_reset();
    int hits;
    stall_cycles = 3;
    dmem_ren   = 1'b1;
    dmem_addr  = 32'h204;
    dmem_width = 2'd2;
    tick();
    dmem_ren = 1'b0;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dhit === 1'b1 || ihit === 1'b1) hits++;
    end
    checks++;
    if (hits != 0 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL withdraw: hits=%0d req=%b required 0 0", hits, ram_req);
    end
    imem_ren  = 1'b1;
    imem_addr = 32'h100;
    tick();
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_addr !== 16'h40) begin
      errors++;
      $display("FAIL reset_pre: req=%b addr=%h required 1 0040", ram_req, ram_addr);
    end
    nrst = 1'b0;
    tick();
    checks++;
    if ({ram_req, ram_wen, ihit, dhit} !== 4'b0000 || ram_addr !== 16'h0 || ram_be !== 4'h0 ||
        ram_wdata !== 32'h0 || imem_load !== 32'h0 || dmem_load !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: req=%b wen=%b ihit=%b dhit=%b addr=%h be=%h wdata=%h iload=%h dload=%h required all 0",
               ram_req, ram_wen, ihit, dhit, ram_addr, ram_be, ram_wdata, imem_load, dmem_load);
    end
    nrst = 1'b1;
    imem_ren = 1'b0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ihit === 1'b1 || ram_req === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL reset_after: stray hit/req cycles=%0d required 0", hits);
    end
    stall_cycles = 0;
  endtask

  initial begin
    nrst = 1'b0;
    imem_ren = 1'b0;
    imem_addr = '0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    dmem_addr = '0;
    dmem_store = '0;
    dmem_width = '0;
    poke_a = '0;
    poke_d = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_store_load();
    test_stall();
`ifdef MEM_ARBITER_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_withdraw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
